// File: rtl/rv_pkg.sv
// Shared register-file write-back types and widths.
package rv_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;
  localparam int unsigned NREGS  = 32;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// In-order load-return queue; exposes per-entry valid/rd for pending-register tracking.
module wb_fifo
  import rv_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            push,
  input  wb_req_t                         din,
  input  logic                            pop,
  output wb_req_t                         dout,
  output logic                            full,
  output logic                            empty,
  output logic [$clog2(DEPTH):0]          count,
  output logic [DEPTH-1:0]                ent_valid,
  output logic [DEPTH-1:0][REG_AW-1:0]    ent_rd
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  wb_req_t          mem [DEPTH];
  logic [DEPTH-1:0] vld;
  logic [PW-1:0]    wp;
  logic [PW-1:0]    rp;
  logic [CW-1:0]    cnt;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rp];
  assign count   = cnt;
  assign ent_valid = vld;

  always_comb begin
    ent_rd = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      ent_rd[i] = mem[i].rd;
    end
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2.
  always_ff @(posedge clk) begin
    if (rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
      vld <= '0;
    end else begin
      if (do_pop) begin
        rp      <= rp + PW'(1);
        vld[rp] <= 1'b0;
      end
      if (do_push) begin
        wp      <= wp + PW'(1);
        vld[wp] <= 1'b1;
      end
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wp] <= din;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: ALU results win, load returns are queued,
// with a starvation guard and WAW protection via the pending-register mask.
module regfile_wb_arbiter
  import rv_pkg::*;
#(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned LQ_DEPTH     = 4,
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        alu_valid,
  input  logic [4:0]                  alu_rd,
  input  logic [XLEN-1:0]             alu_data,
  output logic                        alu_ready,
  input  logic                        ld_valid,
  input  logic [4:0]                  ld_rd,
  input  logic [XLEN-1:0]             ld_data,
  output logic                        ld_ready,
  output logic                        we3,
  output logic [4:0]                  wa3,
  output logic [XLEN-1:0]             wd3,
  output logic [31:0]                 pend_mask,
  output logic [$clog2(LQ_DEPTH):0]   lq_count
);

  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

  wb_req_t                         head;
  wb_req_t                         ld_req;
  logic                            full;
  logic                            empty;
  logic                            push;
  logic                            pop;
  logic [LQ_DEPTH-1:0]             ent_valid;
  logic [LQ_DEPTH-1:0][REG_AW-1:0] ent_rd;
  logic [SW-1:0]                   starve_cnt;
  logic [SW-1:0]                   starve_nxt;
  logic                            starved;
  logic                            waw_block;
  logic                            alu_grant;

  assign ld_req = '{rd: ld_rd, data: ld_data};

  wb_fifo #(.DEPTH(LQ_DEPTH)) u_lq (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .din       (ld_req),
    .pop       (pop),
    .dout      (head),
    .full      (full),
    .empty     (empty),
    .count     (lq_count),
    .ent_valid (ent_valid),
    .ent_rd    (ent_rd)
  );

  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < int'(LQ_DEPTH); i++) begin
      if (ent_valid[i]) begin
        pend_mask[ent_rd[i]] = 1'b1;
      end
    end
  end

  // Loads to x0 are accepted but never queued.
  assign ld_ready  = !full;
  assign push      = ld_valid && ld_ready && (ld_rd != '0);

  assign starved   = (starve_cnt == SW'(STARVE_LIMIT)) && !empty;
  assign waw_block = alu_valid && (alu_rd != '0) && pend_mask[alu_rd];
  assign alu_ready = !starved && !waw_block;
  assign alu_grant = alu_valid && alu_ready && (alu_rd != '0);
  assign pop       = !empty && !alu_grant;

  always_comb begin
    starve_nxt = starve_cnt;
    if (empty || pop) begin
      starve_nxt = '0;
    end else if (alu_grant && (starve_cnt != SW'(STARVE_LIMIT))) begin
      starve_nxt = starve_cnt + SW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      we3        <= 1'b0;
      wa3        <= '0;
      wd3        <= '0;
      starve_cnt <= '0;
    end else begin
      starve_cnt <= starve_nxt;
      if (alu_grant) begin
        we3 <= 1'b1;
        wa3 <= alu_rd;
        wd3 <= alu_data;
      end else if (pop) begin
        we3 <= 1'b1;
        wa3 <= head.rd;
        wd3 <= head.data;
      end else begin
        we3 <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized and directed checks of regfile_wb_arbiter against a queue-based model.
module tb_regfile_wb_arbiter;

  localparam int LQ     = 4;
  localparam int STARVE = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_ready;
  logic        ld_valid;
  logic [4:0]  ld_rd;
  logic [31:0] ld_data;
  logic        ld_ready;
  logic        we3;
  logic [4:0]  wa3;
  logic [31:0] wd3;
  logic [31:0] pend_mask;
  logic [2:0]  lq_count;

  regfile_wb_arbiter #(.XLEN(32), .LQ_DEPTH(LQ), .STARVE_LIMIT(STARVE)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data), .ld_ready(ld_ready),
    .we3(we3), .wa3(wa3), .wd3(wd3), .pend_mask(pend_mask), .lq_count(lq_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit [4:0]  rd;
    bit [31:0] data;
  } ent_t;

  ent_t      q[$];
  int        scnt;
  bit        m_we;
  bit [4:0]  m_wa;
  bit [31:0] m_wd;
  bit        m_alu_acc;
  bit        m_ld_acc;
  bit        s_alu_ready;
  bit [31:0] mdl_rf [32];
  bit [31:0] dut_rf [32];
  int        n_checks = 0;
  int        n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: drive inputs, check combinational outputs, advance model, check write port.
  task automatic cyc(input bit r, input bit av, input bit [4:0] ard, input bit [31:0] ad,
                     input bit lv, input bit [4:0] lrd, input bit [31:0] ldd);
    bit [31:0] pm;
    bit        starved, waw, ar, lr, grant, was_ne;
    ent_t      e;
    @(negedge clk);
    rst = r; alu_valid = av; alu_rd = ard; alu_data = ad;
    ld_valid = lv; ld_rd = lrd; ld_data = ldd;
    #1;
    pm = '0;
    foreach (q[i]) pm[q[i].rd] = 1'b1;
    starved = (scnt == STARVE) && (q.size() != 0);
    waw     = av && (ard != 0) && pm[ard];
    ar      = !starved && !waw;
    lr      = q.size() < LQ;
    s_alu_ready = alu_ready;
    if (!r) begin
      check("alu_ready", alu_ready, ar);
      check("ld_ready", ld_ready, lr);
      check("pend_mask", pend_mask, pm);
      check("lq_count", lq_count, q.size());
    end
    m_alu_acc = !r && av && ar;
    m_ld_acc  = !r && lv && lr;
    if (r) begin
      q.delete();
      scnt = 0; m_we = 0; m_wa = '0; m_wd = '0;
    end else begin
      grant  = av && ar && (ard != 0);
      was_ne = q.size() != 0;
      if (grant) begin
        m_we = 1; m_wa = ard; m_wd = ad;
      end else if (was_ne) begin
        e = q.pop_front();
        m_we = 1; m_wa = e.rd; m_wd = e.data;
      end else begin
        m_we = 0;
      end
      if (!was_ne)     scnt = 0;
      else if (grant)  scnt = (scnt < STARVE) ? scnt + 1 : scnt;
      else             scnt = 0;
      if (lv && lr && (lrd != 0)) q.push_back('{lrd, ldd});
      if (m_we) mdl_rf[m_wa] = m_wd;
    end
    @(posedge clk);
    #1;
    check("we3", we3, m_we);
    check("wa3", wa3, m_wa);
    check("wd3", wd3, m_wd);
    check("x0_write", we3 && (wa3 == 0), 1'b0);
    if (we3) dut_rf[wa3] = wd3;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    int guard;
    bit [4:0] seq [6];
    bit [4:0] exp_seq [6];
    for (int i = 0; i < 32; i++) begin mdl_rf[i] = '0; dut_rf[i] = '0; end
    rst = 1; alu_valid = 0; alu_rd = 0; alu_data = 0; ld_valid = 0; ld_rd = 0; ld_data = 0;
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 4, 32'h1234, 1, 4, 32'h5678);
    check("rst_we3", we3, 0);
    check("rst_wa3", wa3, 0);

    // ALU only
    cyc(0, 1, 5, 32'hDEADBEEF, 0, 0, 0);
    check("alu_we3", we3, 1);
    check("alu_wa3", wa3, 5);
    check("alu_wd3", wd3, 32'hDEADBEEF);
    idle(1);
    check("alu_we3_off", we3, 0);

    // Queue fill while the ALU keeps the port busy
    idle(2);
    k = 1; guard = 0;
    while (k <= 4 && guard < 20) begin
      cyc(0, 1, 20, $urandom, 1, 5'(k), 32'h100 + k);
      if (m_ld_acc) k++;
      guard++;
    end
    check("fill_count", lq_count, 4);
    check("fill_mask", pend_mask, 32'h1E);
    check("fill_ld_ready", ld_ready, 0);
    guard = 0;
    while (k == 5 && guard < 20) begin
      cyc(0, 0, 0, 0, 1, 5, 32'h105);
      if (m_ld_acc) k++;
      guard++;
    end
    check("ld5_accepted", k, 6);
    idle(6);
    check("fill_rf4", dut_rf[4], 32'h104);
    check("fill_rf5", dut_rf[5], 32'h105);

    // Starvation guard
    idle(2);
    cyc(0, 1, 9, 32'h900, 1, 7, 32'h700);
    seq[0] = wa3;
    for (int i = 1; i < 6; i++) begin
      cyc(0, 1, 9, 32'h900 + i, 0, 0, 0);
      seq[i] = wa3;
      if (i == 4) check("starve_alu_blocked", s_alu_ready, 0);
      if (i == 5) check("starve_alu_resume", s_alu_ready, 1);
    end
    exp_seq = '{9, 9, 9, 9, 7, 9};
    foreach (seq[i]) check("starve_seq", seq[i], exp_seq[i]);

    // WAW against a queued load
    idle(2);
    cyc(0, 0, 0, 0, 1, 3, 32'hAAAA0003);
    cyc(0, 1, 3, 32'hBBBB0003, 0, 0, 0);
    check("waw_blocked", s_alu_ready, 0);
    check("waw_load_first", wa3, 3);
    guard = 0;
    do begin
      cyc(0, 1, 3, 32'hBBBB0003, 0, 0, 0);
      guard++;
    end while (!m_alu_acc && guard < 10);
    check("waw_alu_accepted", m_alu_acc, 1);
    idle(1);
    check("waw_final", dut_rf[3], 32'hBBBB0003);

    // x0 handling
    idle(2);
    cyc(0, 0, 0, 0, 1, 0, 32'hCAFE);
    check("ld_x0_count", lq_count, 0);
    cyc(0, 0, 0, 0, 1, 6, 32'h606);
    cyc(0, 1, 0, 32'hFFFF, 0, 0, 0);
    check("alu_x0_ready", s_alu_ready, 1);
    check("alu_x0_pop_we", we3, 1);
    check("alu_x0_pop_wa", wa3, 6);

    // Reset mid-operation
    idle(2);
    cyc(0, 1, 20, 32'h2000, 1, 10, 32'hA0);
    cyc(0, 1, 20, 32'h2001, 1, 11, 32'hA1);
    cyc(0, 1, 20, 32'h2002, 1, 12, 32'hA2);
    check("pre_rst_count", lq_count, 3);
    cyc(1, 1, 21, 32'h2100, 1, 13, 32'hA3);
    check("mid_rst_count", lq_count, 0);
    check("mid_rst_mask", pend_mask, 0);
    check("mid_rst_we3", we3, 0);
    idle(3);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 99) == 0), $urandom_range(0, 1), 5'($urandom_range(0, 7)), $urandom,
          ($urandom_range(0, 2) != 0), 5'($urandom_range(0, 7)), $urandom);
    end
    idle(8);
    for (int i = 0; i < 32; i++) check("rf_final", dut_rf[i], mdl_rf[i]);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
